// File: rtl/load_store_unit.sv
// load_store_unit
// Executes one RV32 load or store per start pulse through a simple
// request/acknowledge memory port.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   start             one-cycle request, sampled only while idle
//   is_load, is_store operation select (exactly one must be set)
//   funct3            access width / sign (b, h, w, bu, hu)
//   base, imm32       effective address operands, ea = base + imm32
//   store_data        rs2 value for stores
//   mem_req..mem_wdata memory request channel, held stable while requesting
//   mem_ack,mem_rdata memory response, sampled only while requesting
//   busy, done, err   status; err qualifies the one-cycle done pulse
//   load_data         extended load result, held until the next done
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [31:0] imm32,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [31:0] ea;
   logic        illegal, misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] rd_shift;

   assign ea = base + imm32;

   // Decode checks use the live inputs since they are only consulted in IDLE.
   always_comb begin
      illegal = (is_load == is_store);
      if (is_load && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
         illegal = 1'b1;
      if (is_store && !(funct3 inside {3'b000, 3'b001, 3'b010}))
         illegal = 1'b1;
      misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                   ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
   end

   // Store lane placement: the datum is replicated so every lane carries it
   // and the byte enables pick out the addressed one.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << ea[1:0];
            st_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << ea[1:0];
            st_wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0 for extraction.
   assign rd_shift = mem_rdata >> {lane_q, 3'b000};

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      funct3_d    = funct3_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               lane_d      = ea[1:0];
               funct3_d    = funct3;
               mem_we_d    = is_store;
               mem_addr_d  = {ea[31:2], 2'b00};
               mem_be_d    = is_store ? st_be : 4'b0000;
               mem_wdata_d = st_wdata;
               cnt_d       = 8'd0;
               err_d       = illegal || misaligned;
               state_d     = (illegal || misaligned) ? FIN : REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (!mem_we_q) begin
                  case (funct3_q)
                     3'b000:  load_data_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
                     3'b001:  load_data_d = {{16{rd_shift[15]}}, rd_shift[15:0]};
                     3'b100:  load_data_d = {24'd0, rd_shift[7:0]};
                     3'b101:  load_data_d = {16'd0, rd_shift[15:0]};
                     default: load_data_d = mem_rdata;
                  endcase
               end
               err_d   = 1'b0;
               state_d = FIN;
            end else if (cnt_q == LAST_CNT) begin
               // An ack in the final allowed cycle still wins over the timeout.
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lane_q      <= 2'b00;
         funct3_q    <= 3'b000;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'd0;
         load_data_q <= 32'd0;
         err_q       <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         funct3_q    <= funct3_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Status decodes straight from the state register so a reset drops
   // mem_req and busy immediately.
   assign mem_req   = (state_q == REQ);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);
   assign err       = (state_q == FIN) && err_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign load_data = load_data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack (range 1..255).
REQ-002 SHALL provide port clk  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  in  1  one-cycle request to execute a load/store; sampled only in IDLE.
REQ-005 SHALL provide port is_load  in  1  the operation is a load (opcode 0000011).
REQ-006 SHALL provide port is_store  in  1  the operation is a store (opcode 0100011).
REQ-007 SHALL provide port funct3  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL provide port base  in  32  rs1 register value.
REQ-009 SHALL provide port imm32  in  32  sign-extended offset from the decoder.
REQ-010 SHALL provide port store_data  in  32  rs2 register value.
REQ-011 SHALL provide port mem_req  out  1  memory request; held until acknowledged.
REQ-012 SHALL provide port mem_we  out  1  1 = write, 0 = read.
REQ-013 SHALL provide port mem_addr  out  32  word-aligned address, {ea[31:2],2'b00}.
REQ-014 SHALL provide port mem_be  out  4  byte enables for writes; 4'b0000 on reads.
REQ-015 SHALL provide port mem_wdata  out  32  lane-positioned write data.
REQ-016 SHALL provide port mem_ack  in  1  memory acknowledge; the transfer completes in a cycle where mem_req and mem_ack are both 1.
REQ-017 SHALL provide port mem_rdata  in  32  read word, valid in the ack cycle.
REQ-018 SHALL provide port busy  out  1  high in every state except IDLE.
REQ-019 SHALL provide port done  out  1  one-cycle completion pulse.
REQ-020 SHALL provide port err  out  1  qualifies done: the operation failed.
REQ-021 SHALL provide port load_data  out  32  extended load result, held until the next done.

Function
REQ-022 SHALL implement the states IDLE, REQ, FIN.
REQ-023 SHALL compute in IDLE, on start: ea = base + imm32 modulo 2^32 (wrap, no overflow flag); latch ea, the operation, funct3 and store_data.
REQ-024 SHALL, on start with a legal, aligned operation, enter REQ in the next cycle, with mem_req = 1 from that cycle.
REQ-025 SHALL treat as illegal: is_load == is_store; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
REQ-026 SHALL treat as misaligned: h/hu with ea[0] = 1; w with ea[1:0] != 0.
REQ-027 SHALL, on an illegal or misaligned operation, go directly to FIN with err = 1, never assert mem_req, and leave load_data unchanged.
REQ-028 SHALL keep mem_req, mem_we, mem_addr, mem_be and mem_wdata stable throughout REQ.
REQ-029 SHALL, on a store, drive sb as mem_wdata = {4{byte}} with be = 0001 << ea[1:0]; sh as {2{half}} with be = 0011 << ea[1:0]; sw as store_data with be = 1111.
REQ-030 SHALL, on a load ack, register load_data from lane ea[1:0]: b/h sign-extended, bu/hu zero-extended, w unchanged.
REQ-031 SHALL, when mem_req and mem_ack are both 1, deassert mem_req in the next cycle and enter FIN with err = 0.
REQ-032 SHALL count REQ cycles with an 8-bit counter; if TIMEOUT cycles elapse without ack, drop mem_req, enter FIN with err = 1, and leave load_data unchanged.
REQ-033 SHALL, in FIN, assert done = 1 for exactly one cycle and then return to IDLE, with err valid in the same cycle as done and 0 otherwise.
REQ-034 SHALL ignore start while busy = 1; no queuing.
REQ-035 SHALL accept a new start in the first IDLE cycle after FIN, for a minimum latency of 3 cycles start-to-done with a zero-wait ack.
REQ-036 SHALL ignore mem_ack outside REQ.

Reset
REQ-037 SHALL, while rst = 0, asynchronously force state IDLE and set mem_req, mem_we, done, err and busy to 0, mem_addr, mem_wdata and load_data to 0, mem_be to 0, and the counter to 0.
REQ-038 SHALL, on reset mid-transfer, abandon the transfer with no done pulse.

Verification
REQ-039 SHALL cover: sw base=0x1000, imm=-4, store_data=0xDEADBEEF, immediate ack -> mem_addr=0x0FFC, be=1111, wdata=0xDEADBEEF, done without err on cycle 3.
REQ-040 SHALL cover: lb ea=0x2003, mem_rdata=0x80FFFFFF -> load_data=0xFFFFFF80; lbu with the same inputs -> 0x00000080.
REQ-041 SHALL cover: sh ea=0x12, store_data=0x0000ABCD -> mem_addr=0x10, be=1100, wdata=0xABCDABCD.
REQ-042 SHALL cover: lw ea=0x6 -> done with err=1, mem_req never asserted, load_data unchanged.
REQ-043 SHALL cover: lw with mem_ack held 0 and TIMEOUT=4 -> mem_req high for exactly 4 cycles, then done with err=1.
REQ-044 SHALL cover: rst asserted during REQ -> mem_req drops immediately, no done; start during busy -> ignored.
